// File: rtl/zephyr_pkg.sv
// Shared encodings for the zregctl register-file sequencer and its ALU.
package zephyr_pkg;

  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_LDI = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD_A = 2'b01,
    RD_B = 2'b10,
    WR   = 2'b11
  } state_e;

  localparam logic RF_OP_READ  = 1'b0;
  localparam logic RF_OP_WRITE = 1'b1;

endpackage

// File: rtl/zalu.sv
// 8-bit add/subtract; carry_o is the carry-out on add and the borrow (a < b) on subtract.
module zalu (
  input  logic       sub_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] res_o,
  output logic       carry_o
);

  logic [8:0] sum;

  always_comb begin
    if (sub_i) sum = {1'b0, a_i} - {1'b0, b_i};
    else       sum = {1'b0, a_i} + {1'b0, b_i};
  end

  assign res_o   = sum[7:0];
  assign carry_o = sum[8];

endmodule

// File: rtl/zregctl.sv
// Sequences MOV/ADD/SUB/LDI over an external 4-entry register file:
// read rd, read rs, then write the result back to rd.
//
// state | meaning
// IDLE  | ready for an instruction, no register-file access
// RD_A  | read rd into operand A (ADD/SUB only)
// RD_B  | read rs into operand B (ADD/SUB/MOV)
// WR    | write result to rd, pulse DONE, update RESULT/flags
module zregctl
  import zephyr_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       INSTR_VALID,
  output logic       INSTR_READY,
  input  logic [7:0] INSTR,
  output logic       RF_EN,
  output logic       RF_OPCODE,
  output logic [1:0] RF_SEL,
  output logic [7:0] RF_WDATA,
  input  logic [7:0] RF_RDATA,
  output logic       DONE,
  output logic [7:0] RESULT,
  output logic       FLAG_Z,
  output logic       FLAG_C
);

  state_e     state_q, state_d;
  logic [7:0] instr_q;
  logic [7:0] opa_q, opb_q;
  logic [7:0] result_q;
  logic       flag_z_q, flag_c_q;

  op_e        op;
  logic [1:0] rd, rs;
  logic [7:0] alu_res, wr_data;
  logic       alu_c;

  assign op = op_e'(instr_q[7:6]);
  assign rd = instr_q[5:4];
  assign rs = instr_q[3:2];

  zalu u_alu (
    .sub_i   (op == OP_SUB),
    .a_i     (opa_q),
    .b_i     (opb_q),
    .res_o   (alu_res),
    .carry_o (alu_c)
  );

  always_comb begin
    unique case (op)
      OP_MOV:  wr_data = opb_q;
      OP_LDI:  wr_data = {4'h0, instr_q[3:0]};
      default: wr_data = alu_res;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    INSTR_READY = 1'b0;
    RF_EN       = 1'b0;
    RF_OPCODE   = RF_OP_READ;
    RF_SEL      = 2'd0;
    RF_WDATA    = 8'h00;
    DONE        = 1'b0;
    unique case (state_q)
      IDLE: begin
        INSTR_READY = 1'b1;
        if (INSTR_VALID) begin
          unique case (op_e'(INSTR[7:6]))
            OP_MOV:  state_d = RD_B;
            OP_LDI:  state_d = WR;
            default: state_d = RD_A;
          endcase
        end
      end
      RD_A: begin
        RF_EN   = 1'b1;
        RF_SEL  = rd;
        state_d = RD_B;
      end
      RD_B: begin
        RF_EN   = 1'b1;
        RF_SEL  = rs;
        state_d = WR;
      end
      WR: begin
        RF_EN     = 1'b1;
        RF_OPCODE = RF_OP_WRITE;
        RF_SEL    = rd;
        RF_WDATA  = wr_data;
        DONE      = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      instr_q  <= 8'h00;
      opa_q    <= 8'h00;
      opb_q    <= 8'h00;
      result_q <= 8'h00;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && INSTR_VALID) instr_q <= INSTR;
      if (state_q == RD_A) opa_q <= RF_RDATA;
      if (state_q == RD_B) opb_q <= RF_RDATA;
      if (state_q == WR) begin
        result_q <= wr_data;
        flag_z_q <= (wr_data == 8'h00);
        // Carry is architectural state of the arithmetic ops only.
        if (op == OP_ADD || op == OP_SUB) flag_c_q <= alu_c;
      end
    end
  end

  assign RESULT = result_q;
  assign FLAG_Z = flag_z_q;
  assign FLAG_C = flag_c_q;

endmodule
